load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding, access decode and the DATA_W legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    // lg = log2(access bytes); sign = sign-extend load result
    typedef struct packed {
        logic       legal;
        logic [1:0] lg;
        logic       sign;
    } lsu_dec_t;

    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

    // Unsigned codes exist only for loads; doubleword codes only on 64-bit
    function automatic lsu_dec_t lsu_decode(input logic [2:0] f3, input logic store,
                                            input logic wide);
        lsu_dec_t d;
        d = '{legal: 1'b0, lg: 2'd0, sign: 1'b0};
        case (f3)
            F3_B:    d = '{legal: 1'b1,            lg: 2'd0, sign: 1'b1};
            F3_H:    d = '{legal: 1'b1,            lg: 2'd1, sign: 1'b1};
            F3_W:    d = '{legal: 1'b1,            lg: 2'd2, sign: 1'b1};
            F3_D:    d = '{legal: wide,            lg: 2'd3, sign: 1'b1};
            F3_BU:   d = '{legal: !store,          lg: 2'd0, sign: 1'b0};
            F3_HU:   d = '{legal: !store,          lg: 2'd1, sign: 1'b0};
            F3_WU:   d = '{legal: !store && wide,  lg: 2'd2, sign: 1'b0};
            default: d = '{legal: 1'b0,            lg: 2'd0, sign: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes and lane-rotated write
// data for either beat, and load extraction/extension from a two-word window.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [OFF_W-1:0]  i_off,
    input  logic [1:0]        i_lg,
    input  logic              i_sign,
    input  logic              i_beat,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_lo,
    input  logic [DATA_W-1:0] i_hi,
    output logic [NB-1:0]     o_we,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    int                  w_off;
    int                  w_sz;
    logic [2*NB-1:0]     w_mask2;
    logic [2*DATA_W-1:0] w_shift;
    logic [DATA_W-1:0]   w_keep;
    logic [DATA_W-1:0]   w_top;
    logic                w_neg;

    assign w_off = int'(i_off);
    assign w_sz  = 1 << i_lg;

    // Lane mask over two words; upper half is the spill into the next word.
    // Lane i carries data byte (i - off) mod size, which is plain replication
    // when aligned and a rotation that lines up both halves when split.
    always_comb begin
        w_mask2 = '0;
        o_wdata = '0;
        for (int i = 0; i < 2*NB; i++)
            w_mask2[i] = (i >= w_off) && (i < w_off + w_sz);
        for (int i = 0; i < NB; i++)
            for (int k = 0; k < NB; k++)
                if (k == ((i - w_off) & (w_sz - 1)))
                    o_wdata[i*8 +: 8] = i_wdata[k*8 +: 8];
        o_we = i_beat ? w_mask2[2*NB-1:NB] : w_mask2[NB-1:0];
    end

    // Load: shift the {hi,lo} window down to the access, then extend
    always_comb begin
        w_keep  = '0;
        w_top   = '0;
        w_shift = {i_hi, i_lo} >> {i_off, 3'b000};
        for (int b = 0; b < DATA_W; b++) begin
            w_keep[b] = (b < 8 * w_sz);
            w_top[b]  = (b == 8 * w_sz - 1);
        end
        w_neg   = i_sign && |(w_shift[DATA_W-1:0] & w_top);
        o_rdata = (w_shift[DATA_W-1:0] & w_keep) | (w_neg ? ~w_keep : '0);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RISC-V memory op, issues one or two memory
// beats with a per-beat timeout, and returns an extended load result.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two
// beats; otherwise they complete immediately with a fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [DATA_W-1:0]   req_base,
    input  logic [DATA_W-1:0]   req_imm,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_fault
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    generate
        if (!data_w_legal(DATA_W)) begin : g_bad_data_w
            $error("load_store_unit: DATA_W must be 32 or 64");
        end
    endgenerate

    lsu_state_e          r_state, w_next;
    logic [ADDR_W-1:0]   r_word;
    logic [OFF_W-1:0]    r_off;
    logic [1:0]          r_lg;
    logic                r_sign, r_store, r_split, r_fault;
    logic [DATA_W-1:0]   r_wdata, r_beat0, r_rsp;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:0]   w_sum;
    logic [ADDR_W-1:0]   w_ea;
    lsu_dec_t            w_dec;
    logic                w_mis, w_fault_now, w_split_now;
    logic                w_accept, w_in_beat, w_expire;
    logic [NB-1:0]       w_we;
    logic [DATA_W-1:0]   w_wdata, w_rdata;

    assign w_sum = req_base + req_imm;
    assign w_ea  = ADDR_W'(w_sum);
    assign w_dec = lsu_decode(req_funct3, req_store, DATA_W == 64);
    assign w_mis = ({1'b0, w_ea[OFF_W-1:0]} + ((OFF_W+1)'(1) << w_dec.lg))
                   > (OFF_W+1)'(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_fault_now = !w_dec.legal;
    assign w_split_now = w_dec.legal && w_mis;
`else
    assign w_fault_now = !w_dec.legal || w_mis;
    assign w_split_now = 1'b0;
`endif

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_in_beat = (r_state == S_BEAT0) || (r_state == S_BEAT1);
    assign w_expire  = (r_cnt == CNT_W'(TIMEOUT - 1));

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_off   (r_off),
        .i_lg    (r_lg),
        .i_sign  (r_sign),
        .i_beat  (r_state == S_BEAT1),
        .i_wdata (r_wdata),
        .i_lo    (r_split ? r_beat0 : mem_rdata),
        .i_hi    (mem_rdata),
        .o_we    (w_we),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and outputs; a mem_ack in the expiring cycle wins over timeout
    always_comb begin
        w_next    = r_state;
        req_ready = (r_state == S_IDLE);
        mem_req   = w_in_beat;
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        rsp_valid = (r_state == S_RESP);
        rsp_data  = '0;
        rsp_fault = 1'b0;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_fault_now ? S_RESP : S_BEAT0;
            S_BEAT0: if (mem_ack)       w_next = r_split ? S_BEAT1 : S_RESP;
                     else if (w_expire) w_next = S_RESP;
            S_BEAT1: if (mem_ack || w_expire) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_in_beat) begin
            mem_addr = r_word + ((r_state == S_BEAT1) ? ADDR_W'(NB) : '0);
            if (r_store) begin
                mem_we    = w_we;
                mem_wdata = w_wdata;
            end
        end
        if (r_state == S_RESP) begin
            rsp_data  = r_rsp;
            rsp_fault = r_fault;
        end
    end

    // Request capture, beat counter, split-beat buffer and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_off   <= '0;
            r_lg    <= '0;
            r_sign  <= 1'b0;
            r_store <= 1'b0;
            r_split <= 1'b0;
            r_fault <= 1'b0;
            r_wdata <= '0;
            r_beat0 <= '0;
            r_rsp   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_word  <= {w_ea[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_off   <= w_ea[OFF_W-1:0];
            r_lg    <= w_dec.lg;
            r_sign  <= w_dec.sign;
            r_store <= req_store;
            r_split <= w_split_now;
            r_fault <= w_fault_now;
            r_wdata <= req_wdata;
            r_rsp   <= '0;
            r_cnt   <= '0;
        end else if (w_in_beat) begin
            if (mem_ack) begin
                r_cnt <= '0;
                if ((r_state == S_BEAT0) && r_split) r_beat0 <= mem_rdata;
                else if (!r_store)                   r_rsp   <= w_rdata;
            end else if (w_expire) begin
                r_fault <= 1'b1;
                r_rsp   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (DATA_W=32, TIMEOUT=16).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_imm, req_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
        .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, play memory (ack after ack_dly extra cycles per beat,
    // never if negative) and report first-beat signals and the response.
    // lat = negedges from the accepting edge to rsp_valid, -1 if none in 40.
    task automatic xact(input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] wd, input int ack_dly,
                        input logic [31:0] rd0, input logic [31:0] rd1,
                        output logic [31:0] a0, output logic [3:0] we0,
                        output logic [31:0] wd0, output int lat,
                        output logic [31:0] data, output logic flt,
                        output logic anyreq);
        int          bc;
        logic [31:0] pa;
        a0 = '0; we0 = '0; wd0 = '0; lat = -1; data = '0; flt = 1'b0;
        anyreq = 1'b0; bc = 0; pa = '1;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_base = base; req_imm = imm; req_wdata = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_req) begin
                if (!anyreq) begin a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata; end
                anyreq    = 1'b1;
                bc        = (mem_addr == pa) ? bc + 1 : 1;
                pa        = mem_addr;
                mem_rdata = (mem_addr == a0) ? rd0 : rd1;
                mem_ack   = (ack_dly >= 0) && (bc == ack_dly + 1);
            end else begin
                mem_ack = 1'b0;
            end
            if (rsp_valid) begin
                lat = c; data = rsp_data; flt = rsp_fault;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    logic [31:0] a0, wd0, data;
    logic [3:0]  we0;
    logic        flt, anyreq, seen;
    int          lat;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_base = '0; req_imm = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data,  0);
        rst_n = 1'b1;

        // LW 0x100+4, ack one cycle after mem_req
        xact(0, 3'b010, 32'h100, 32'h4, 0, 1, 32'hDEADBEEF, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("lw_addr",  a0,     32'h104);
        chk("lw_we",    we0,    0);
        chk("lw_lat",   lat,    3);
        chk("lw_data",  data,   32'hDEADBEEF);
        chk("lw_fault", flt,    0);

        // LB / LBU at 0x103
        xact(0, 3'b000, 32'h100, 32'h3, 0, 1, 32'h80112233, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("lb_addr", a0,   32'h100);
        chk("lb_data", data, 32'hFFFFFF80);
        xact(0, 3'b100, 32'h100, 32'h3, 0, 1, 32'h80112233, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("lbu_data", data, 32'h00000080);

        // LH / LHU at 0x106 via negative offset
        xact(0, 3'b001, 32'h10A, 32'hFFFFFFFC, 0, 1, 32'h80017FFF, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("lh_addr", a0,   32'h104);
        chk("lh_data", data, 32'hFFFF8001);
        xact(0, 3'b101, 32'h10A, 32'hFFFFFFFC, 0, 1, 32'h80017FFF, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("lhu_data", data, 32'h00008001);

        // SH at 0x102
        xact(1, 3'b001, 32'h100, 32'h2, 32'h0000ABCD, 1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("sh_we",    we0,  4'b1100);
        chk("sh_wdata", wd0,  32'hABCDABCD);
        chk("sh_data",  data, 0);
        chk("sh_fault", flt,  0);

        // SB at 0x101, SW at 0x200
        xact(1, 3'b000, 32'hFF, 32'h2, 32'h12345678, 1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("sb_addr",  a0,  32'h100);
        chk("sb_we",    we0, 4'b0010);
        chk("sb_wdata", wd0, 32'h78787878);
        xact(1, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("sw_we",    we0, 4'b1111);
        chk("sw_wdata", wd0, 32'hCAFEF00D);

        // LW at 0x102 (crosses a word)
        xact(0, 3'b010, 32'h100, 32'h2, 0, 1, 32'h33445566, 32'h77881122, a0, we0, wd0, lat, data, flt, anyreq);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("mis_req",   anyreq, 1);
        chk("mis_addr",  a0,     32'h100);
        chk("mis_lat",   lat,    5);
        chk("mis_data",  data,   32'h11223344);
        chk("mis_fault", flt,    0);
`else
        chk("mis_req",   anyreq, 0);
        chk("mis_lat",   lat,    1);
        chk("mis_data",  data,   0);
        chk("mis_fault", flt,    1);
`endif

        // Illegal codes: LD on 32-bit, funct3 111, store with unsigned code
        xact(0, 3'b011, 32'h100, 0, 0, 1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("ld32_fault", flt, 1);
        chk("ld32_req",   anyreq, 0);
        xact(0, 3'b111, 32'h100, 0, 0, 1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("f3_111_fault", flt, 1);
        xact(1, 3'b100, 32'h100, 0, 32'h55, 1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("sbu_fault", flt, 1);
        chk("sbu_req",   anyreq, 0);

        // Timeout: mem_ack withheld
        xact(0, 3'b010, 32'h400, 0, 0, -1, 0, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("to_lat",   lat,  17);
        chk("to_fault", flt,  1);
        chk("to_data",  data, 0);
        @(negedge clk);
        chk("to_ready", req_ready, 1);

        // mem_ack in the expiring cycle wins
        xact(0, 3'b010, 32'h400, 0, 0, 15, 32'h0BADCAFE, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("win_lat",   lat,  17);
        chk("win_fault", flt,  0);
        chk("win_data",  data, 32'h0BADCAFE);

        // Stray mem_ack while idle
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h12345678; seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || mem_req) seen = 1'b1;
        end
        mem_ack = 1'b0;
        chk("stray_ignored", seen, 0);
        chk("stray_ready",   req_ready, 1);

        // Reset during BEAT0
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_base = 32'h300; req_imm = 0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_req_pre", mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req,   0);
        chk("rst_mid_addr",    mem_addr,  0);
        chk("rst_mid_ready",   req_ready, 1);
        chk("rst_mid_rsp",     rsp_valid, 0);
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_mid_no_rsp", seen, 0);
        xact(0, 3'b010, 32'h300, 32'h8, 0, 1, 32'hA5A5_5A5A, 0, a0, we0, wd0, lat, data, flt, anyreq);
        chk("post_rst_addr", a0,   32'h308);
        chk("post_rst_lat",  lat,  3);
        chk("post_rst_data", data, 32'hA5A55A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
